db9md_pad_scanner: RTL
======================

// Module: db9md_pad_scanner
// PURPOSE
//  Scans two Sega Mega Drive / Atari-style pads sharing one SNAC DB9 port (6 pins + split + select).
//  Drives split/select, samples 8 select phases per player and decodes 3/6-button pads.
//  Publishes active-high 16-bit button words to the top-level joystick mux (SNAC mode in status[31:30]).
// PARAMETERS
//  STEP_CYCLES  480    clk_sys cycles per select phase (10 us at 48 MHz); min 2
//  IDLE_CYCLES  96000  gap after both players scanned (2 ms, > pad 1.5 ms 6-btn timeout); min 1
// PORTS
//  clk_sys     in   1   system clock, 48 MHz; sole clock
//  reset       in   1   synchronous, active-high
//  joy_in      in   6   pad pins, active-low: [0]Up [1]Down [2]Left [3]Right [4]pin6 B/A [5]pin9 C/Start
//  joy_split   out  1   pad select: 0 = player 1, 1 = player 2
//  joy_mdsel   out  1   Mega Drive SEL line (pin 7)
//  joystick1   out  16  player 1 buttons, active-high (map below)
//  joystick2   out  16  player 2 buttons, active-high
//  scan_done   out  1   1-cycle pulse when a player's word is committed
// BEHAVIOUR
//  Word map: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z [12]six_btn [13]md_pad [15:14]=0
//  Reset: joy_split=0, joy_mdsel=1, joystick1/2=0, scan_done=0, FSM->SETTLE(player 1), counters 0.
//  Reset mid-scan aborts; captured partial data is discarded, never committed.
//  FSM: SETTLE -> PH0..PH7 -> COMMIT -> (player1 ? SETTLE(player 2) : IDLE) ; IDLE -> SETTLE(player 1).
//   SETTLE: STEP_CYCLES, joy_mdsel=1, joy_split set to target player (split changes only on entry).
//   PHk: STEP_CYCLES each; joy_mdsel = 1 for even k, 0 for odd k; joy_in sampled on last cycle of phase.
//   COMMIT: 1 cycle; decoded word written to joystick1 or joystick2; scan_done=1 this cycle only.
//   IDLE: IDLE_CYCLES, joy_mdsel=1, joy_split=0.
//  Decode (p = ~joy_in sampled in phase):
//   PH0: U,D,L,R,B=p[4],C=p[5].
//   PH1: md_pad = p[2]&p[1]&p[0]... no: md_pad = p[2]&p[3] (Left,Right both low); A=p[4], Start=p[5] iff md_pad.
//   PH5: six_btn = md_pad & p[0]&p[1]&p[2]&p[3].
//   PH6: Z=p[0], Y=p[1], X=p[2], Mode=p[3] iff six_btn.
//   PH2-4,PH7: drive only, samples ignored.
//   !md_pad: A,Start,X,Y,Z,Mode,six_btn = 0; U/D/L/R/B/C still from PH0 (Atari/SMS pad).
//   md_pad & !six_btn: X,Y,Z,Mode = 0.
//  Latency: joy_in change visible in word <= 2*(9*STEP_CYCLES+1)+IDLE_CYCLES cycles.
//  Counters are width-sized from parameters; no wrap inside a phase; no combinational in->out paths.
// CONFIGURATION
//  DB9MD_DEBOUNCE_EN defined: per player, COMMIT writes only if decoded word equals that player's
//   previous decoded scan (held in a shadow reg, reset 0); scan_done still pulses every COMMIT.
//  Undefined: every COMMIT writes the fresh decoded word; no shadow registers.
// STRUCTURE
//  Package db9md_pkg: state enum (SETTLE,PH0..PH7,COMMIT,IDLE), word bit-index localparams, NUM_PHASES=8.
//  Sub-module db9md_capture: phase-indexed sample regs + decode to 16-bit word; instantiated once,
//   cleared on SETTLE entry, shared by both players.
// TESTING (bench: STEP_CYCLES=4, IDLE_CYCLES=16, pad model responds to split/sel per MD 6-btn protocol)
//  6-btn pad P1, Start+Z held -> after first P1 COMMIT joystick1=16'h3880, joystick2=0.
//  3-btn pad P2, Right+A held (PH5 UDLR not low) -> joystick2=16'h2041, bits[11:8]=0.
//  Atari pad (PH1 L/R high), Up+B held -> word=16'h0018, md_pad=0, A/Start=0 even if pins low.
//  Sequence check: split toggles only at SETTLE entry; mdsel pattern 1,1,0,1,0,1,0,1,0 per player; 1 scan_done per player.
//  Reset asserted during P2 PH4 -> outputs 0, joy_split=0, joy_mdsel=1 next cycle; no P2 commit.
//  DB9MD_DEBOUNCE_EN: B glitch for one scan only -> word unchanged; held 2 scans -> bit4 set on 2nd COMMIT.

Source files
------------

// File: rtl/db9md_pkg.sv
// -----------------------------------------------------------------------------
// db9md_pkg
// Shared definitions for the DB9 Mega Drive / Atari pad scanner:
//   - state_t      : scan FSM states (SETTLE, PH0..PH7, COMMIT, IDLE)
//   - BIT_*        : bit positions inside the 16-bit active-high button word
//   - NUM_PHASES   : number of select phases scanned per player
//   - mdsel_for()  : SEL line level driven in a given state
//   - phase_index(): 0..7 index of a PHk state
// No ports (package).
// -----------------------------------------------------------------------------
package db9md_pkg;

    localparam int NUM_PHASES = 8;

    typedef enum logic [3:0] {
        SETTLE = 4'd0,
        PH0    = 4'd1,
        PH1    = 4'd2,
        PH2    = 4'd3,
        PH3    = 4'd4,
        PH4    = 4'd5,
        PH5    = 4'd6,
        PH6    = 4'd7,
        PH7    = 4'd8,
        COMMIT = 4'd9,
        IDLE   = 4'd10
    } state_t;

    localparam int BIT_R     = 0;
    localparam int BIT_L     = 1;
    localparam int BIT_D     = 2;
    localparam int BIT_U     = 3;
    localparam int BIT_B     = 4;
    localparam int BIT_C     = 5;
    localparam int BIT_A     = 6;
    localparam int BIT_START = 7;
    localparam int BIT_MODE  = 8;
    localparam int BIT_X     = 9;
    localparam int BIT_Y     = 10;
    localparam int BIT_Z     = 11;
    localparam int BIT_SIX   = 12;
    localparam int BIT_MD    = 13;

    // SEL is low only in the odd phases; every other state parks it high.
    function automatic logic mdsel_for(input state_t s);
        logic sel;
        case (s)
            PH1, PH3, PH5, PH7: sel = 1'b0;
            default:            sel = 1'b1;
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] phase_index(input state_t s);
        logic [2:0] idx;
        case (s)
            PH0:     idx = 3'd0;
            PH1:     idx = 3'd1;
            PH2:     idx = 3'd2;
            PH3:     idx = 3'd3;
            PH4:     idx = 3'd4;
            PH5:     idx = 3'd5;
            PH6:     idx = 3'd6;
            PH7:     idx = 3'd7;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/db9md_capture.sv
// -----------------------------------------------------------------------------
// db9md_capture
// Holds the pad pins sampled in the phases that carry information (PH0, PH1,
// PH5, PH6) and decodes them into the 16-bit active-high button word.
// One instance is shared by both players; it is cleared when a player's
// SETTLE begins so data never leaks from one player (or an aborted scan)
// into the next commit.
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_clear   clear all sample registers
//   i_sample  store i_joy for phase i_phase (last cycle of that phase)
//   i_phase   phase index 0..7
//   i_joy     pad pins, active-low
//   o_word    decoded button word (from registers only)
// -----------------------------------------------------------------------------
module db9md_capture
    import db9md_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_sample,
    input  logic [2:0]  i_phase,
    input  logic [5:0]  i_joy,
    output logic [15:0] o_word
);

    // Stored values are already inverted to active-high.
    logic [5:0]  r_ph0;     // U D L R B C
    logic [3:0]  r_ph1;     // [0]L [1]R [2]A [3]Start
    logic [3:0]  r_ph5;     // U D L R (all high => six-button pad)
    logic [3:0]  r_ph6;     // [0]Z [1]Y [2]X [3]Mode
    logic        w_md_pad;
    logic        w_six_btn;
    logic [15:0] w_word;

    // Phase-indexed sample registers.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_ph0 <= 6'd0;
            r_ph1 <= 4'd0;
            r_ph5 <= 4'd0;
            r_ph6 <= 4'd0;
        end else if (i_sample) begin
            case (i_phase)
                3'd0:    r_ph0 <= ~i_joy;
                3'd1:    r_ph1 <= ~i_joy[5:2];
                3'd5:    r_ph5 <= ~i_joy[3:0];
                3'd6:    r_ph6 <= ~i_joy[3:0];
                default: r_ph0 <= r_ph0;
            endcase
        end else begin
            r_ph0 <= r_ph0;
        end
    end

    // Decode: A/Start need an MD pad (Left+Right low with SEL low);
    // X/Y/Z/Mode additionally need the six-button signature in PH5.
    always_comb begin
        w_md_pad  = r_ph1[0] & r_ph1[1];
        w_six_btn = w_md_pad & (&r_ph5);
        w_word    = 16'd0;
        w_word[BIT_U]     = r_ph0[0];
        w_word[BIT_D]     = r_ph0[1];
        w_word[BIT_L]     = r_ph0[2];
        w_word[BIT_R]     = r_ph0[3];
        w_word[BIT_B]     = r_ph0[4];
        w_word[BIT_C]     = r_ph0[5];
        w_word[BIT_A]     = w_md_pad & r_ph1[2];
        w_word[BIT_START] = w_md_pad & r_ph1[3];
        w_word[BIT_Z]     = w_six_btn & r_ph6[0];
        w_word[BIT_Y]     = w_six_btn & r_ph6[1];
        w_word[BIT_X]     = w_six_btn & r_ph6[2];
        w_word[BIT_MODE]  = w_six_btn & r_ph6[3];
        w_word[BIT_SIX]   = w_six_btn;
        w_word[BIT_MD]    = w_md_pad;
    end

    assign o_word = w_word;

endmodule

// File: rtl/db9md_pad_scanner.sv
// -----------------------------------------------------------------------------
// db9md_pad_scanner
// Scans two Mega Drive / Atari pads sharing one SNAC DB9 port. For each
// player: SETTLE (split set, SEL high), eight select phases PH0..PH7, then a
// one-cycle COMMIT that publishes the decoded word. After player 2 an IDLE
// gap lets six-button pads time out before the next round.
// Optional feature macro: DB9MD_DEBOUNCE_EN -- when defined, a commit only
// updates a player's word if it matches that player's previous decoded scan.
// Parameters:
//   STEP_CYCLES  cycles per SETTLE / select phase (min 2)
//   IDLE_CYCLES  cycles of IDLE gap (min 1)
// Ports:
//   clk_sys     system clock
//   reset       synchronous active-high reset
//   joy_in      pad pins, active-low [0]U [1]D [2]L [3]R [4]B/A [5]C/Start
//   joy_split   0 = player 1 pad, 1 = player 2 pad
//   joy_mdsel   Mega Drive SEL line
//   joystick1   player 1 word, active-high
//   joystick2   player 2 word, active-high
//   scan_done   one-cycle pulse during each COMMIT
// All outputs are registered.
// -----------------------------------------------------------------------------
module db9md_pad_scanner
    import db9md_pkg::*;
#(
    parameter int STEP_CYCLES = 480,
    parameter int IDLE_CYCLES = 96000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_split,
    output logic        joy_mdsel,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        scan_done
);

    localparam int CNT_MAX = (STEP_CYCLES > IDLE_CYCLES) ? STEP_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_player;
    logic             w_next_player;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_sample;
    logic             w_clear;
    logic             w_commit;
    logic             w_accept;
    logic [15:0]      w_word;

    logic             r_joy_split;
    logic             r_joy_mdsel;
    logic [15:0]      r_joystick1;
    logic [15:0]      r_joystick2;
    logic             r_scan_done;

    // Next-state and player selection.
    always_comb begin
        w_next_state  = r_state;
        w_next_player = r_player;
        w_last        = 1'b0;
        if (r_state == IDLE) begin
            w_last = (r_cnt == IDLE_LAST);
        end else if (r_state == COMMIT) begin
            w_last = 1'b1;
        end else begin
            w_last = (r_cnt == STEP_LAST);
        end
        case (r_state)
            SETTLE, PH0, PH1, PH2, PH3, PH4, PH5, PH6: begin
                // Encodings are consecutive, so +1 walks SETTLE->PH0->..->PH7.
                if (w_last) begin
                    w_next_state = state_t'(r_state + 4'd1);
                end else begin
                    w_next_state = r_state;
                end
            end
            PH7: begin
                if (w_last) begin
                    w_next_state = COMMIT;
                end else begin
                    w_next_state = PH7;
                end
            end
            COMMIT: begin
                if (r_player) begin
                    w_next_state  = IDLE;
                    w_next_player = 1'b0;
                end else begin
                    w_next_state  = SETTLE;
                    w_next_player = 1'b1;
                end
            end
            IDLE: begin
                if (w_last) begin
                    w_next_state  = SETTLE;
                    w_next_player = 1'b0;
                end else begin
                    w_next_state  = IDLE;
                end
            end
            default: begin
                w_next_state  = SETTLE;
                w_next_player = 1'b0;
            end
        endcase
    end

    // Capture strobes derived from the current state.
    always_comb begin
        w_sample = (r_state != SETTLE) && (r_state != COMMIT) && (r_state != IDLE) && w_last;
        w_clear  = (w_next_state == SETTLE) && (r_state != SETTLE);
        w_commit = (r_state == PH7) && w_last;
    end

    db9md_capture u_capture (
        .i_clk    (clk_sys),
        .i_reset  (reset),
        .i_clear  (w_clear),
        .i_sample (w_sample),
        .i_phase  (phase_index(r_state)),
        .i_joy    (joy_in),
        .o_word   (w_word)
    );

`ifdef DB9MD_DEBOUNCE_EN
    logic [15:0] r_shadow1;
    logic [15:0] r_shadow2;

    // Previous decoded scan per player, refreshed on every commit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_shadow1 <= 16'd0;
            r_shadow2 <= 16'd0;
        end else if (w_commit) begin
            if (r_player) begin
                r_shadow2 <= w_word;
            end else begin
                r_shadow1 <= w_word;
            end
        end else begin
            r_shadow1 <= r_shadow1;
        end
    end

    // Publish only a word seen on two consecutive scans.
    always_comb begin
        if (r_player) begin
            w_accept = (w_word == r_shadow2);
        end else begin
            w_accept = (w_word == r_shadow1);
        end
    end
`else
    // Every commit publishes the fresh word.
    always_comb begin
        w_accept = 1'b1;
    end
`endif

    // FSM state, phase counter and registered outputs. Outputs are computed
    // from the next state so they line up with the state they belong to.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= SETTLE;
            r_player    <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_joy_split <= 1'b0;
            r_joy_mdsel <= 1'b1;
            r_joystick1 <= 16'd0;
            r_joystick2 <= 16'd0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_player    <= w_next_player;
            if (w_next_state != r_state) begin
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // next_player only moves on entry to SETTLE/IDLE, so split does too.
            r_joy_split <= (w_next_state == IDLE) ? 1'b0 : w_next_player;
            r_joy_mdsel <= mdsel_for(w_next_state);
            r_scan_done <= w_commit;
            if (w_commit && w_accept) begin
                if (r_player) begin
                    r_joystick2 <= w_word;
                end else begin
                    r_joystick1 <= w_word;
                end
            end
        end
    end

    assign joy_split = r_joy_split;
    assign joy_mdsel = r_joy_mdsel;
    assign joystick1 = r_joystick1;
    assign joystick2 = r_joystick2;
    assign scan_done = r_scan_done;

endmodule
